// File: rtl/block_mac_pkg.sv
// Shared types and constants for the 2x2 block multiply-accumulate stage.
// Holds the FSM encoding, accumulator tags and the fixed partial-product order.
package block_mac_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int MUL_LAT_DEF = 2;
  localparam int N_PROD      = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] TAG_C11 = 2'd0;
  localparam logic [1:0] TAG_C12 = 2'd1;
  localparam logic [1:0] TAG_C21 = 2'd2;
  localparam logic [1:0] TAG_C22 = 2'd3;

  // Operand selects index {x11, x12, x21, x22} = {0, 1, 2, 3}.
  typedef struct packed {
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] tag;
  } prod_ord_t;

  function automatic prod_ord_t prod_order(input logic [2:0] idx);
    prod_ord_t r;
    r = '0;
    case (idx)
      3'd0: r = '{2'd0, 2'd0, TAG_C11};
      3'd1: r = '{2'd1, 2'd2, TAG_C11};
      3'd2: r = '{2'd0, 2'd1, TAG_C12};
      3'd3: r = '{2'd1, 2'd3, TAG_C12};
      3'd4: r = '{2'd2, 2'd0, TAG_C21};
      3'd5: r = '{2'd3, 2'd2, TAG_C21};
      3'd6: r = '{2'd2, 2'd1, TAG_C22};
      3'd7: r = '{2'd3, 2'd3, TAG_C22};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/block_mac_2x2_mul_pipe.sv
// Pipelined multiplier: product, valid and destination tag emerge lat cycles after issue.
// Only the low data_w bits are kept; they are identical for signed and unsigned operands.
module mul_pipe #(
  parameter int data_w = 32,
  parameter int lat    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [1:0]        tag_i,
  input  logic [data_w-1:0] a_i,
  input  logic [data_w-1:0] b_i,
  output logic              vld_o,
  output logic [1:0]        tag_o,
  output logic [data_w-1:0] prod_o
);

  logic [lat-1:0]    vld_q;
  logic [1:0]        tag_q  [lat];
  logic [data_w-1:0] prod_q [lat];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < lat; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0]  <= tag_i;
    prod_q[0] <= a_i * b_i;
    for (int i = 1; i < lat; i++) begin
      tag_q[i]  <= tag_q[i-1];
      prod_q[i] <= prod_q[i-1];
    end
  end

  assign vld_o  = vld_q[lat-1];
  assign tag_o  = tag_q[lat-1];
  assign prod_o = prod_q[lat-1];

endmodule

// File: rtl/block_mac_2x2.sv
// 2x2 block multiply-accumulate: C += A*B using one shared multiplier over 8 partial products.
// done_mac fires mul_lat+9 cycles after the start edge; start/clear are ignored while busy.
module block_mac_2x2
  import block_mac_pkg::*;
#(
  parameter int data_w  = DATA_W_DEF,
  parameter int mul_lat = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_mac,
  input  logic              acc_clr,
  input  logic [data_w-1:0] a_11,
  input  logic [data_w-1:0] a_12,
  input  logic [data_w-1:0] a_21,
  input  logic [data_w-1:0] a_22,
  input  logic [data_w-1:0] b_11,
  input  logic [data_w-1:0] b_12,
  input  logic [data_w-1:0] b_21,
  input  logic [data_w-1:0] b_22,
  output logic [data_w-1:0] c_11,
  output logic [data_w-1:0] c_12,
  output logic [data_w-1:0] c_21,
  output logic [data_w-1:0] c_22,
  output logic              done_mac,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [2:0]        issue_cnt_q, issue_cnt_d;
  logic [3:0]        retire_cnt_q, retire_cnt_d;
  logic [data_w-1:0] a_q [4];
  logic [data_w-1:0] b_q [4];
  logic [data_w-1:0] acc_q [4];
  logic              accept;
  logic              issue_vld;
  prod_ord_t         ord;
  logic              ret_vld;
  logic [1:0]        ret_tag;
  logic [data_w-1:0] ret_prod;

  assign accept = (state_q == S_IDLE) && start_mac;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mac) state_d = S_ISSUE;
      S_ISSUE: if (issue_cnt_q == 3'd7) state_d = S_DRAIN;
      // Look at the post-retire count so DONE follows the final retire edge directly.
      S_DRAIN: if (retire_cnt_d == 4'(N_PROD)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done_mac  = (state_q == S_DONE);
    issue_vld = (state_q == S_ISSUE);
  end

  always_comb begin
    issue_cnt_d  = issue_cnt_q;
    retire_cnt_d = retire_cnt_q + {3'b0, ret_vld};
    if (accept) begin
      issue_cnt_d  = '0;
      retire_cnt_d = '0;
    end else if (issue_vld) begin
      issue_cnt_d = issue_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      issue_cnt_q  <= issue_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q[0] <= a_11;
      a_q[1] <= a_12;
      a_q[2] <= a_21;
      a_q[3] <= a_22;
      b_q[0] <= b_11;
      b_q[1] <= b_12;
      b_q[2] <= b_21;
      b_q[3] <= b_22;
    end
  end

  assign ord = prod_order(issue_cnt_q);

  mul_pipe #(
    .data_w (data_w),
    .lat    (mul_lat)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (issue_vld),
    .tag_i  (ord.tag),
    .a_i    (a_q[ord.a_sel]),
    .b_i    (b_q[ord.b_sel]),
    .vld_o  (ret_vld),
    .tag_o  (ret_tag),
    .prod_o (ret_prod)
  );

  always_ff @(posedge clk) begin
    if (rst || ((state_q == S_IDLE) && acc_clr)) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else if (ret_vld) begin
      acc_q[ret_tag] <= acc_q[ret_tag] + ret_prod;
    end
  end

  assign c_11 = acc_q[TAG_C11];
  assign c_12 = acc_q[TAG_C12];
  assign c_21 = acc_q[TAG_C21];
  assign c_22 = acc_q[TAG_C22];

endmodule

// File: tb/tb_block_mac_2x2.sv
// Randomized bench for block_mac_2x2 against a plain matrix-arithmetic model of C += A*B.
// Also checks cycle-exact done/busy timing, ignored mid-run requests and mid-run reset.
module tb_block_mac_2x2;

  logic        clk = 1'b0;
  logic        rst, start_mac, acc_clr, done_mac, busy;
  logic [31:0] a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22;
  logic [31:0] c_11, c_12, c_21, c_22;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_c [4];

  always #5 clk = ~clk;

  block_mac_2x2 #(.data_w(32), .mul_lat(2)) dut (
    .clk(clk), .rst(rst), .start_mac(start_mac), .acc_clr(acc_clr),
    .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
    .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
    .c_11(c_11), .c_12(c_12), .c_21(c_21), .c_22(c_22),
    .done_mac(done_mac), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_c(input string tag, input logic [31:0] e0, e1, e2, e3);
    chk({tag, "_c11"}, c_11, e0);
    chk({tag, "_c12"}, c_12, e1);
    chk({tag, "_c21"}, c_21, e2);
    chk({tag, "_c22"}, c_22, e3);
  endtask

  task automatic set_ops(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
    a_11 = a[0]; a_12 = a[1]; a_21 = a[2]; a_22 = a[3];
    b_11 = b[0]; b_12 = b[1]; b_21 = b[2]; b_22 = b[3];
  endtask

  // mode 0: plain run, 1: start/clear pulsed while busy, 2: reset asserted in cycle T+5
  task automatic run_block(input string tag, input logic [3:0][31:0] a,
                           input logic [3:0][31:0] b, input logic clr, input int mode);
    logic [31:0]      exp_c [4];
    logic [3:0][31:0] junk;
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    set_ops(a, b);
    acc_clr   = clr;
    start_mac = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        exp_c[2*i+j] = (clr ? 32'd0 : model_c[2*i+j]) + a[2*i]*b[j] + a[2*i+1]*b[2+j];
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_mac = 1'b0;
        acc_clr   = 1'b0;
        for (int i = 0; i < 4; i++) junk[i] = $urandom;
        set_ops(junk, junk);
      end
      if (mode == 2 && k == 6) begin
        check_c({tag, "_rst"}, 32'd0, 32'd0, 32'd0, 32'd0);
        chk({tag, "_rst_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_rst_done"}, {31'b0, done_mac}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_c[i] = 32'd0;
        for (int w = 0; w < 12; w++) begin
          @(negedge clk);
          chk({tag, "_no_done"}, {31'b0, done_mac}, 32'd0);
        end
        return;
      end
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      chk({tag, "_done"}, {31'b0, done_mac}, {31'b0, (k == 11)});
      if (k == 11) begin
        check_c(tag, exp_c[0], exp_c[1], exp_c[2], exp_c[3]);
        for (int i = 0; i < 4; i++) model_c[i] = exp_c[i];
      end
      if (mode == 1 && k == 3) begin
        junk = {4{32'h7}};
        set_ops(junk, junk);
        start_mac = 1'b1;
        acc_clr   = 1'b1;
      end
      if (mode == 1 && k == 4) begin
        start_mac = 1'b0;
        acc_clr   = 1'b0;
      end
      if (mode == 2 && k == 5) rst = 1'b1;
    end
  endtask

  initial begin
    logic [3:0][31:0] a, b;
    rst = 1'b1; start_mac = 1'b0; acc_clr = 1'b0;
    a = '0;
    set_ops(a, a);
    for (int i = 0; i < 4; i++) model_c[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_c("reset", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done_mac}, 32'd0);
    rst = 1'b0;

    a = {32'd4, 32'd3, 32'd2, 32'd1};
    b = {32'd8, 32'd7, 32'd6, 32'd5};
    run_block("basic", a, b, 1'b1, 0);
    check_c("basic_ref", 32'd19, 32'd22, 32'd43, 32'd50);
    run_block("accum", a, b, 1'b0, 0);
    check_c("accum_ref", 32'd38, 32'd44, 32'd86, 32'd100);

    run_block("neg", {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFD}, {32'd0, 32'd0, 32'd0, 32'd4}, 1'b1, 0);
    check_c("neg_ref", 32'hFFFF_FFF4, 32'd0, 32'd0, 32'd0);
    run_block("wrap", {32'd0, 32'd0, 32'd0, 32'h0001_0000}, {32'd0, 32'd0, 32'd0, 32'h0001_0001}, 1'b1, 0);
    check_c("wrap_ref", 32'h0001_0000, 32'd0, 32'd0, 32'd0);

    run_block("inject", a, b, 1'b1, 1);
    check_c("inject_ref", 32'd19, 32'd22, 32'd43, 32'd50);

    run_block("midrst", a, b, 1'b0, 2);
    run_block("after_rst", a, b, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = (r < 4) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
        b[i] = (r < 4) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      end
      run_block("rand", a, b, 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    chk("final_busy", {31'b0, busy}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_mac_2x2.md
Name: block_mac_2x2

Overview:
- Downstream compute stage of the matrix multiply control unit.
- Accepts one 2x2 A block and one 2x2 B block per start pulse and computes the 2x2 product.
- Adds that product into four persistent C accumulators, so the control unit can sweep k and accumulate one C block.
- Uses one pipelined multiplier and one adder, time-shared over the 8 partial products; pulses done when the accumulators hold the updated block.

Parameters:
- data_w, 32: operand/accumulator width, signed two's complement.
- mul_lat, 2: multiplier pipeline latency in cycles, must be at least 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start_mac  in  1  one-cycle request; sampled only in IDLE.
- acc_clr  in  1  zero the accumulators; sampled only in IDLE.
- a_11, a_12, a_21, a_22  in  data_w each  A block operands.
- b_11, b_12, b_21, b_22  in  data_w each  B block operands.
- c_11, c_12, c_21, c_22  out  data_w each  accumulator values, registered.
- done_mac  out  1  one-cycle pulse; c_* are final in that cycle.
- busy  out  1  high from the cycle after start is accepted through the done_mac cycle.

Behaviour:
- Reset: state IDLE. c_* = 0, done_mac = 0, busy = 0. Issue counter, retire counter and all pipeline valid bits are cleared. Reset mid-operation aborts with no done_mac; the in-flight result is discarded.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - acc_clr=1 zeroes c_* at the clock edge, with or without start_mac.
  - start_mac=1 latches all 8 operands into internal registers, clears the counters and moves to ISSUE.
  - If acc_clr and start_mac are both high, accumulation starts from 0.
  - Operand inputs are don't-care after the accept edge.
- ISSUE: lasts 8 cycles. Issues one product per cycle in this fixed order, each tagged with its destination:
  - p0 a11*b11 -> c11, p1 a12*b21 -> c11
  - p2 a11*b12 -> c12, p3 a12*b22 -> c12
  - p4 a21*b11 -> c21, p5 a22*b21 -> c21
  - p6 a21*b12 -> c22, p7 a22*b22 -> c22
  - After p7, move to DRAIN.
- Retire: a product issued in cycle t is added into its tagged accumulator at the edge ending cycle t+mul_lat. Only one retire per cycle, so there are no adder conflicts. Retire counter increments on each retire.
- DRAIN: wait until the retire count reaches 8, then move to DONE.
- DONE: done_mac=1 for exactly one cycle, busy=1, then return to IDLE.
- Latency: start accepted at edge of cycle T. Issue occupies T+1..T+8. done_mac is high in cycle T+9+mul_lat, which is T+11 at the default.
  - Back-to-back: start_mac may be asserted in the cycle after done_mac.
- Arithmetic:
  - Signed data_w x data_w multiply to a 2*data_w product; keep the low data_w bits.
  - Accumulate modulo 2^data_w, wrap-around with no saturation and no overflow flag.
- start_mac or acc_clr asserted while busy: ignored, with no effect on the result or the accumulators.
- c_* change only on retire edges or an IDLE clear.

Decomposition:
- Shared package block_mac_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - 2-bit destination tag constants (C11=0, C12=1, C21=2, C22=3)
  - product order table
  - default data_w and mul_lat
- Sub-module mul_pipe: mul_lat-stage signed multiplier carrying a valid bit and a 2-bit tag alongside the product.
- The top level holds the FSM, operand latch, counters, the issue mux and the accumulator bank.

Test Plan:
- A=[1,2;3,4], B=[5,6;7,8], acc_clr=1 with start_mac at T -> done_mac only in T+11; c=[19,22;43,50]; busy high T+1..T+11.
- Repeat the same operands with acc_clr=0 right after done -> c=[38,44;86,100].
- a_11=0xFFFFFFFD (-3), b_11=4, all else 0, acc_clr=1 -> c_11=0xFFFFFFF4; other c_* = 0.
- a_11=0x00010000, b_11=0x00010001, acc_clr=1 -> c_11=0x00010000, showing the wrap.
- Start the first scenario, then at T+3 drive all operands to 0x7 and pulse start_mac and acc_clr -> result unchanged at [19,22;43,50]; single done_mac.
- Start the first scenario, assert rst in T+5 -> next cycle c_*=0, busy=0; no done_mac afterwards; a new start then completes normally.
